// File: rtl/rocstar_mcu_link.sv
// rocstar_mcu_link
// Rocstar-board end of one mcu lane. It owns the free-running board clock
// counter. It decodes the command nibble sent by mcu_logic and returns
// framed counter snapshots on the byte lane. Each frame is:
// header {HDR_NIB, seq}, NB payload bytes (MSB first), then an XOR checksum.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset (released synchronously upstream)
//   cmd_in    command nibble: 1 CNT_CLR, 3 SNAP, 4 CNT_STOP, 5 CNT_RUN
//   lane_out  registered byte lane; IDLE_BYTE when no frame is in flight
//   busy      frame on the lane or a snapshot request pending
//   clkcnt    board clock counter
//   seq       sequence number of the next frame
//   ovf_cnt   saturating count of dropped snapshot requests
module rocstar_mcu_link #(
  parameter int         CNT_W     = 48,
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter logic [3:0] HDR_NIB   = 4'hB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       cmd_in,
  output logic [7:0]       lane_out,
  output logic             busy,
  output logic [CNT_W-1:0] clkcnt,
  output logic [3:0]       seq,
  output logic [7:0]       ovf_cnt
);

  localparam int                 NB    = CNT_W / 8;
  localparam int                 IDX_W = $clog2(NB + 1);
  localparam logic [IDX_W-1:0]   NB_L  = IDX_W'(NB);
  localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CSUM} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cmd_q;
  logic             running;
  logic             pending, pending_nxt;
  logic [7:0]       lane_nxt;
  logic [3:0]       seq_nxt;
  logic [7:0]       ovf_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             load_snap, shift_snap;
  logic [CNT_W-1:0] snap;
  logic [7:0]       csum, csum_nxt;
  logic             fire, snap_fire;
  logic [3:0]       seq_inc;

  // A command fires only on the rising edge of a nonzero nibble out of zero.
  assign fire      = (cmd_in != 4'd0) && (cmd_q == 4'd0);
  assign snap_fire = fire && (cmd_in == 4'd3);
  assign seq_inc   = seq + 4'd1;

  // pending is only ever set while a frame occupies the lane.
  assign busy = (state != S_IDLE) || pending;

  // ---- command capture and clock counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= 4'd0;
      running <= 1'b1;
      clkcnt  <= '0;
    end else begin
      cmd_q <= cmd_in;
      if (fire && cmd_in == 4'd1)
        clkcnt <= '0;
      else if (running)
        clkcnt <= clkcnt + ONE;
      if (fire && cmd_in == 4'd4)
        running <= 1'b0;
      else if (fire && cmd_in == 4'd5)
        running <= 1'b1;
    end
  end

  // ---- frame sequencer: next state and next lane byte ----
  always_comb begin
    state_nxt   = state;
    lane_nxt    = lane_out;
    pending_nxt = pending;
    seq_nxt     = seq;
    ovf_nxt     = ovf_cnt;
    idx_nxt     = idx;
    csum_nxt    = csum;
    load_snap   = 1'b0;
    shift_snap  = 1'b0;
    case (state)
      S_IDLE: begin
        if (snap_fire) begin
          state_nxt = S_HDR;
          lane_nxt  = {HDR_NIB, seq};
          csum_nxt  = {HDR_NIB, seq};
          load_snap = 1'b1;
          idx_nxt   = '0;
        end
      end
      S_HDR, S_PAY: begin
        if (idx == NB_L) begin
          state_nxt = S_CSUM;
          lane_nxt  = csum;
        end else begin
          state_nxt  = S_PAY;
          lane_nxt   = snap[CNT_W-1 -: 8];
          csum_nxt   = csum ^ snap[CNT_W-1 -: 8];
          shift_snap = 1'b1;
          idx_nxt    = idx + 1'b1;
        end
        if (snap_fire) begin
          if (!pending)
            pending_nxt = 1'b1;
          else if (ovf_cnt != 8'hFF)
            ovf_nxt = ovf_cnt + 8'd1;
        end
      end
      S_CSUM: begin
        seq_nxt = seq_inc;
        idx_nxt = '0;
        // A request arriving on the closing edge chains straight on; if one was
        // already pending, the new one takes its place as the pending request.
        if (pending || snap_fire) begin
          state_nxt   = S_HDR;
          lane_nxt    = {HDR_NIB, seq_inc};
          csum_nxt    = {HDR_NIB, seq_inc};
          load_snap   = 1'b1;
          pending_nxt = pending && snap_fire;
        end else begin
          state_nxt = S_IDLE;
          lane_nxt  = IDLE_BYTE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        lane_nxt  = IDLE_BYTE;
      end
    endcase
  end

  // ---- sequencer control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lane_out <= IDLE_BYTE;
      pending  <= 1'b0;
      seq      <= 4'd0;
      ovf_cnt  <= 8'd0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      lane_out <= lane_nxt;
      pending  <= pending_nxt;
      seq      <= seq_nxt;
      ovf_cnt  <= ovf_nxt;
      idx      <= idx_nxt;
    end
  end

  // ---- snapshot shift register and running checksum (data only) ----
  always_ff @(posedge clk) begin
    csum <= csum_nxt;
    if (load_snap)
      snap <= clkcnt;
    else if (shift_snap)
      snap <= {snap[CNT_W-9:0], 8'h00};
  end

endmodule

// File: tb/tb_rocstar_mcu_link.sv
// Bench for rocstar_mcu_link: a byte-stream reference model predicts every
// post-edge output; records go into a scoreboard queue and a monitor compares
// them one cycle at a time. A second 8-bit instance exercises counter wrap.
module tb_rocstar_mcu_link;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cmd_in;
  logic [7:0]  lane_out;
  logic        busy;
  logic [47:0] clkcnt;
  logic [3:0]  seq;
  logic [7:0]  ovf_cnt;

  logic [3:0]  s_cmd = 4'd0;
  logic [7:0]  s_lane;
  logic        s_busy;
  logic [7:0]  s_clkcnt;
  logic [3:0]  s_seq;
  logic [7:0]  s_ovf;

  always #5 clk = ~clk;

  rocstar_mcu_link dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .lane_out(lane_out),
    .busy(busy), .clkcnt(clkcnt), .seq(seq), .ovf_cnt(ovf_cnt)
  );

  rocstar_mcu_link #(.CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .cmd_in(s_cmd), .lane_out(s_lane),
    .busy(s_busy), .clkcnt(s_clkcnt), .seq(s_seq), .ovf_cnt(s_ovf)
  );

  typedef struct {
    logic [7:0]  lane;
    logic        bsy;
    logic [47:0] cnt;
    logic [3:0]  sq;
    logic [7:0]  ovf;
    logic [7:0]  scnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cap[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;

  // Reference model state
  logic [47:0] m_cnt;
  bit          m_run;
  logic [3:0]  m_prev;
  logic [3:0]  m_seq;
  int          m_ovf;
  bit          m_showing;
  bit          m_pend;
  logic [7:0]  m_stream[$];
  logic [7:0]  m_scnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_run = 1'b1; m_prev = 4'd0; m_seq = 4'd0; m_ovf = 0;
    m_showing = 1'b0; m_pend = 1'b0; m_stream.delete(); m_scnt = 8'd0;
  endtask

  task automatic push_frame(input logic [47:0] v);
    logic [7:0] b, x;
    x = {4'hB, m_seq};
    m_stream.push_back(x);
    for (int i = 5; i >= 0; i--) begin
      b = 8'((v >> (8 * i)) & 48'hFF);
      m_stream.push_back(b);
      x = x ^ b;
    end
    m_stream.push_back(x);
  endtask

  // Advance the model by one clock edge with command nibble c applied.
  task automatic model_edge(input logic [3:0] c);
    logic [47:0] pre;
    bit f, frame_end, started;
    exp_t e;
    pre = m_cnt;
    f = (c != 4'd0) && (m_prev == 4'd0);
    m_prev = c;
    frame_end = m_showing && (m_stream.size() == 0);
    if (frame_end) m_seq = m_seq + 4'd1;
    started = 1'b0;
    if (frame_end && m_pend) begin
      push_frame(pre);
      m_pend = 1'b0;
      started = 1'b1;
    end
    if (f && c == 4'd3) begin
      if (!started && m_stream.size() == 0) push_frame(pre);
      else if (!m_pend) m_pend = 1'b1;
      else if (m_ovf < 255) m_ovf++;
    end
    if (f && c == 4'd1) m_cnt = '0;
    else if (m_run) m_cnt = m_cnt + 48'd1;
    if (f && c == 4'd4) m_run = 1'b0;
    if (f && c == 4'd5) m_run = 1'b1;
    if (m_stream.size() > 0) begin
      e.lane = m_stream.pop_front();
      m_showing = 1'b1;
    end else begin
      e.lane = 8'h00;
      m_showing = 1'b0;
    end
    m_scnt = m_scnt + 8'd1;
    e.bsy = m_showing || m_pend;
    e.cnt = m_cnt;
    e.sq = m_seq;
    e.ovf = 8'(m_ovf);
    e.scnt = m_scnt;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] c);
    @(negedge clk);
    cmd_in = c;
    model_edge(c);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cmd_in = 4'd0;
    model_edge(4'd0);
  endtask

  // Monitor: one expected record per clock edge after reset release.
  always @(posedge clk) begin
    #1;
    if (mon_en && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (lane_out !== e.lane || busy !== e.bsy || clkcnt !== e.cnt ||
          seq !== e.sq || ovf_cnt !== e.ovf || s_clkcnt !== e.scnt) begin
        miscompares++;
        $display("FAIL cycle t=%0t: lane %h/%h busy %b/%b clkcnt %h/%h seq %h/%h ovf %0d/%0d scnt %h/%h",
                 $time, lane_out, e.lane, busy, e.bsy, clkcnt, e.cnt, seq, e.sq,
                 ovf_cnt, e.ovf, s_clkcnt, e.scnt);
      end
      if (busy) cap.push_back(lane_out);
    end
  end

  initial begin
    logic [7:0] lit [8];
    logic [7:0] h0;
    int guard;
    logic [3:0] c;
    lit = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'hA0};
    rst_n = 1'b0;
    cmd_in = 4'd0;
    model_reset();
    #12;
    check("reset lane", 64'(lane_out), 64'h00);
    check("reset busy", 64'(busy), 64'h0);
    check("reset clkcnt", 64'(clkcnt), 64'h0);
    check("reset seq", 64'(seq), 64'h0);
    check("reset ovf", 64'(ovf_cnt), 64'h0);
    mon_en = 1'b1;
    release_rst();
    repeat (5) step(4'd0);

    // Single SNAP when the counter reads 0x10
    guard = 0;
    while (m_cnt != 48'h10 && guard < 100) begin step(4'd0); guard++; end
    cap.delete();
    step(4'd3);
    repeat (12) step(4'd0);
    check("frame length", 64'(cap.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      check($sformatf("frame byte %0d", i), 64'(cap[i]), 64'(lit[i]));
    check("seq after frame", 64'(seq), 64'd1);

    // SNAP held for 20 cycles
    cap.delete();
    repeat (20) step(4'd3);
    repeat (10) step(4'd0);
    check("held frame length", 64'(cap.size()), 64'd8);
    check("held ovf", 64'(ovf_cnt), 64'd0);

    // Three pulses inside one frame
    cap.delete();
    h0 = {4'hB, m_seq};
    for (int i = 0; i < 3; i++) begin step(4'd3); step(4'd0); end
    repeat (20) step(4'd0);
    check("b2b length", 64'(cap.size()), 64'd16);
    if (cap.size() >= 16) begin
      check("b2b hdr0", 64'(cap[0]), 64'(h0));
      check("b2b hdr1", 64'(cap[8]), 64'({4'hB, h0[3:0] + 4'd1}));
    end
    check("b2b ovf", 64'(ovf_cnt), 64'd1);

    // Stop / run gap, then clear mid-frame
    step(4'd4);
    repeat (10) step(4'd0);
    step(4'd5);
    repeat (3) step(4'd0);
    step(4'd3); step(4'd0); step(4'd0); step(4'd1);
    repeat (10) step(4'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55) c = 4'd0;
      else if (r < 78) c = 4'd3;
      else if (r < 82) c = 4'd1;
      else if (r < 86) c = 4'd4;
      else if (r < 93) c = 4'd5;
      else c = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 3)) step(c);
    end
    step(4'd5);
    repeat (40) step(4'd0);

    // Reset in the middle of a frame
    step(4'd3); step(4'd0); step(4'd0); step(4'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async lane", 64'(lane_out), 64'h00);
    check("async busy", 64'(busy), 64'h0);
    check("async clkcnt", 64'(clkcnt), 64'h0);
    check("async seq", 64'(seq), 64'h0);
    repeat (2) @(negedge clk);
    release_rst();
    repeat (20) step(4'd0);
    step(4'd3);
    repeat (12) step(4'd0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
